// File: rtl/bcd_subtractor_serial_if.sv
// Handshake and operand/result bundle for the digit-serial BCD subtractor.
//
// Signals:
//   start    - request pulse from the controller, sampled by the subtractor in IDLE
//   a, b     - packed BCD minuend / subtrahend, digit 0 in [3:0]
//   busy     - subtraction or magnitude-correction pass in progress
//   done     - one-cycle pulse when diff/negative/invalid are valid
//   diff     - packed BCD magnitude |a - b|
//   negative - a < b (never set together with a zero diff)
//   invalid  - an operand nibble was greater than 9
//
// Modports: master = controller side, slave = subtractor side.
interface bcd_subtractor_serial_if #(
  parameter int DIGITS = 4
) ();

  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   diff;
  logic                  negative;
  logic                  invalid;

  modport master (
    output start, a, b,
    input  busy, done, diff, negative, invalid
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, negative, invalid
  );

endinterface

// File: rtl/bcd_subtractor_serial.sv
// Digit-serial BCD subtractor producing |a - b| plus a sign flag.
// One digit is processed per clock, least significant digit first. When the
// borrow out of the top digit shows a < b, a second pass ten's-complements
// the work register in place to turn the wrapped result into a magnitude.
//
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - slave side of bcd_subtractor_serial_if (start/a/b in,
//           busy/done/diff/negative/invalid out, all outputs registered)
module bcd_subtractor_serial #(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  bcd_subtractor_serial_if.slave    bus
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SUB,
    S_NEG,
    S_DONE
  } state_t;

  state_t           state_q;
  state_t           state_next;

  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     work_q;
  logic [IDX_W-1:0] idx_q;
  logic             borrow_q;

  logic             busy_q;
  logic             done_q;
  logic [W-1:0]     diff_q;
  logic             negative_q;
  logic             invalid_q;

  logic [IDX_W+1:0] nib_lsb;
  logic             last_digit;
  logic             in_bad;
  logic [3:0]       op_lhs;
  logic [3:0]       op_rhs;
  logic [4:0]       t;
  logic [3:0]       digit;
  logic             borrow_n;

  // True when any nibble of the packed vector is not a decimal digit.
  function automatic logic has_bad_nibble(input logic [W-1:0] v);
    has_bad_nibble = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[i*4 +: 4] > 4'd9) has_bad_nibble = 1'b1;
    end
  endfunction

  assign nib_lsb    = {idx_q, 2'b00};
  assign last_digit = (idx_q == IDX_W'(DIGITS - 1));
  assign in_bad     = has_bad_nibble(bus.a) | has_bad_nibble(bus.b);

  // One BCD digit step. In SUB it is a[idx] - b[idx] - borrow; in NEG the
  // minuend is zero and the subtrahend is the work digit, which yields the
  // ten's complement of the wrapped result. A negative 5-bit result is
  // folded back into 0..9 by adding ten and raising the borrow.
  always_comb begin
    op_lhs   = 4'd0;
    op_rhs   = work_q[nib_lsb +: 4];
    if (state_q == S_SUB) begin
      op_lhs = a_q[nib_lsb +: 4];
      op_rhs = b_q[nib_lsb +: 4];
    end
    t        = {1'b0, op_lhs} - {1'b0, op_rhs} - {4'b0000, borrow_q};
    digit    = t[3:0];
    borrow_n = 1'b0;
    if (t[4]) begin
      digit    = t[3:0] + 4'd10;
      borrow_n = 1'b1;
    end
  end

  // Sequencing: invalid operands skip straight to DONE, a final borrow
  // diverts through the complement pass, everything else finishes after SUB.
  always_comb begin
    state_next = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_next = in_bad ? S_DONE : S_SUB;
      S_SUB:  if (last_digit) state_next = borrow_n ? S_NEG : S_DONE;
      S_NEG:  if (last_digit) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_next;
  end

  // Datapath and registered outputs. done is raised on the edge that leaves
  // DONE, together with diff, so the result and the pulse appear together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      work_q     <= '0;
      idx_q      <= '0;
      borrow_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      diff_q     <= '0;
      negative_q <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      done_q <= (state_q == S_DONE);
      busy_q <= (state_next == S_SUB) || (state_next == S_NEG);
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            work_q     <= '0;
            idx_q      <= '0;
            borrow_q   <= 1'b0;
            diff_q     <= '0;
            negative_q <= 1'b0;
            invalid_q  <= in_bad;
          end
        end
        S_SUB: begin
          work_q[nib_lsb +: 4] <= digit;
          if (last_digit) begin
            idx_q    <= '0;
            borrow_q <= 1'b0;
            if (borrow_n) negative_q <= 1'b1;
          end else begin
            idx_q    <= idx_q + 1'b1;
            borrow_q <= borrow_n;
          end
        end
        S_NEG: begin
          work_q[nib_lsb +: 4] <= digit;
          if (last_digit) begin
            idx_q    <= '0;
            borrow_q <= 1'b0;
          end else begin
            idx_q    <= idx_q + 1'b1;
            borrow_q <= borrow_n;
          end
        end
        S_DONE: begin
          diff_q <= work_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.diff     = diff_q;
  assign bus.negative = negative_q;
  assign bus.invalid  = invalid_q;

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// Self-checking bench for bcd_subtractor_serial. Expected results come from
// an integer-arithmetic model of |a - b| over decimal operand values.
module tb_bcd_subtractor_serial;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic clk;
  logic rst_n;

  int tests;
  int fails;

  bcd_subtractor_serial_if #(.DIGITS(DIGITS)) bus ();

  bcd_subtractor_serial #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal value of a packed BCD word.
  function automatic int bcd_to_int(input logic [W-1:0] v);
    int r;
    int scale;
    r = 0;
    scale = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r = r + int'(v[i*4 +: 4]) * scale;
      scale = scale * 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference: decimal subtraction, sign, validity, and timing expectations.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] e_diff, output logic e_neg,
                       output logic e_inv, output int e_lat, output int e_busy);
    int av;
    int bv;
    e_inv = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[i*4 +: 4] > 4'd9 || b[i*4 +: 4] > 4'd9) e_inv = 1'b1;
    end
    if (e_inv) begin
      e_diff = '0;
      e_neg  = 1'b0;
      e_lat  = 1;
      e_busy = 0;
    end else begin
      av = bcd_to_int(a);
      bv = bcd_to_int(b);
      e_neg  = (av < bv);
      e_diff = int_to_bcd(e_neg ? bv - av : av - bv);
      e_lat  = e_neg ? 2 * DIGITS + 1 : DIGITS + 1;
      e_busy = e_neg ? 2 * DIGITS : DIGITS;
    end
  endtask

  // Launch one operation and measure it. restart_at >= 0 re-pulses start
  // (with different operands) that many edges after the sampling edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int restart_at,
                        output int lat, output int busy_cycles,
                        output int extra_done, output bit timeout,
                        output logic [W-1:0] d, output logic ng, output logic iv,
                        output logic [W-1:0] hold_d, output logic hold_ng,
                        output logic hold_iv);
    int k;
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    k = 0;
    busy_cycles = 0;
    timeout = 1'b0;
    while (bus.done !== 1'b1 && !timeout) begin
      if (bus.busy === 1'b1) busy_cycles++;
      if (k == restart_at) begin
        bus.a = ~a;
        bus.b = a;
        bus.start = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      k++;
      if (k > 64) timeout = 1'b1;
    end
    lat = k;
    d  = bus.diff;
    ng = bus.negative;
    iv = bus.invalid;
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) extra_done++;
    end
    hold_d  = bus.diff;
    hold_ng = bus.negative;
    hold_iv = bus.invalid;
  endtask

  task automatic test_reset();
    tests++;
    if (bus.busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    tests++;
    if (bus.done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
    tests++;
    if (bus.diff !== '0) begin fails++; $display("[TB] FAIL reset_diff: got %h expected 0", bus.diff); end
    tests++;
    if (bus.negative !== 1'b0 || bus.invalid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_flags: got neg=%b inv=%b expected 0 0", bus.negative, bus.invalid);
    end
  endtask

  // Shared body for directed and random operations: run, then compare every
  // observable against the model.
  task automatic check_case(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input int restart_at);
    logic [W-1:0] e_diff, d, hd;
    logic e_neg, e_inv, ng, iv, hng, hiv;
    int e_lat, e_busy, lat, bc, extra;
    bit to;
    model(a, b, e_diff, e_neg, e_inv, e_lat, e_busy);
    run_op(a, b, restart_at, lat, bc, extra, to, d, ng, iv, hd, hng, hiv);
    tests++;
    if (to) begin
      fails++;
      $display("[TB] FAIL %s_timeout: a=%h b=%h no done within 64 edges", name, a, b);
    end else begin
      tests++;
      if (d !== e_diff) begin fails++; $display("[TB] FAIL %s_diff: a=%h b=%h got %h expected %h", name, a, b, d, e_diff); end
      tests++;
      if (ng !== e_neg) begin fails++; $display("[TB] FAIL %s_negative: a=%h b=%h got %b expected %b", name, a, b, ng, e_neg); end
      tests++;
      if (iv !== e_inv) begin fails++; $display("[TB] FAIL %s_invalid: a=%h b=%h got %b expected %b", name, a, b, iv, e_inv); end
      tests++;
      if (lat !== e_lat) begin fails++; $display("[TB] FAIL %s_latency: a=%h b=%h got %0d expected %0d", name, a, b, lat, e_lat); end
      tests++;
      if (bc !== e_busy) begin fails++; $display("[TB] FAIL %s_busy_cycles: a=%h b=%h got %0d expected %0d", name, a, b, bc, e_busy); end
      tests++;
      if (extra !== 0) begin fails++; $display("[TB] FAIL %s_extra_done: a=%h b=%h got %0d expected 0", name, a, b, extra); end
      tests++;
      if (hd !== e_diff || hng !== e_neg || hiv !== e_inv) begin
        fails++;
        $display("[TB] FAIL %s_hold: got %h/%b/%b expected %h/%b/%b", name, hd, hng, hiv, e_diff, e_neg, e_inv);
      end
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [7];
    logic [W-1:0] vb [7];
    va = '{16'h5000, 16'h1234, 16'h1000, 16'h0000, 16'h4321, 16'h9999, 16'h0001};
    vb = '{16'h1234, 16'h5000, 16'h0001, 16'h9999, 16'h4321, 16'h0000, 16'h0002};
    for (int i = 0; i < 7; i++) check_case("directed", va[i], vb[i], -1);
  endtask

  task automatic test_invalid_recovery();
    check_case("invalid", 16'h0A00, 16'h0001, -1);
    check_case("invalid_b", 16'h0123, 16'h00F0, -1);
    check_case("after_invalid", 16'h0042, 16'h0007, -1);
  endtask

  task automatic test_start_while_busy();
    check_case("ignore_start_eq", 16'h4321, 16'h4321, 2);
    check_case("ignore_start_neg", 16'h0010, 16'h0999, 5);
  endtask

  task automatic test_reset_abort();
    int extra;
    @(negedge clk);
    bus.a = 16'h5000;
    bus.b = 16'h1234;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.diff !== '0 ||
        bus.negative !== 1'b0 || bus.invalid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL abort_outputs: got busy=%b done=%b diff=%h neg=%b inv=%b expected all 0",
               bus.busy, bus.done, bus.diff, bus.negative, bus.invalid);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) extra++;
    end
    tests++;
    if (extra !== 0) begin fails++; $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", extra); end
    check_case("after_abort", 16'h5000, 16'h1234, -1);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < DIGITS; i++) begin
        a[i*4 +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
        b[i*4 +: 4] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 9) == 0) b = a;
      check_case("random", a, b, -1);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_directed();
    test_invalid_recovery();
    test_start_while_busy();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_subtractor_serial.md
Name: bcd_subtractor_serial

Overview:
- Digit-serial signed BCD subtractor; the inverse-direction companion to the calculator's BCD add path.
- Computes |A − B| and a sign flag for two unsigned multi-digit BCD operands, processing one digit per clock, LSD first.
- Uses a start/busy/done handshake so the calculator control FSM can launch a subtraction and collect the result.
- Sits beside the BCD adder chain in the calculator datapath and feeds the display/result register.

Parameters:
- DIGITS, 4, number of BCD digits per operand and result (≥ 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  4*DIGITS  minuend, packed BCD, digit 0 in [3:0].
- b  input  4*DIGITS  subtrahend, packed BCD, same packing.
- busy  output  1  high while an operation is in progress (SUB or NEG state).
- done  output  1  one-cycle pulse when the result is valid.
- diff  output  4*DIGITS  magnitude |a − b|, packed BCD.
- negative  output  1  1 when a < b; never 1 when diff is 0.
- invalid  output  1  1 when any input nibble was > 9.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy, done, negative and invalid go to 0; diff goes to 0.
  - Internal digit index, borrow and operand/work registers are cleared.
  - Reset mid-operation aborts with no done pulse.
- States: IDLE, SUB, NEG, DONE.
- IDLE:
  - On start=1, capture a and b, set borrow=0 and idx=0, and clear diff, negative and invalid.
  - If any nibble of a or b is > 9, go to DONE with invalid=1 and diff=0.
  - Otherwise go to SUB.
- SUB, one digit per cycle:
  - t = a[idx] − b[idx] − borrow, computed at 5-bit signed width.
  - If t < 0, digit = t + 10 and borrow = 1; else digit = t and borrow = 0.
  - Write digit to work[idx] and increment idx.
  - After digit DIGITS−1: if the final borrow = 0, go to DONE.
  - If the final borrow = 1, set negative=1, idx=0, borrow=0, and go to NEG.
- NEG: ten's-complement pass over the work register to produce the magnitude.
  - Per cycle, t = 0 − work[idx] − borrow, with the same correction rule as SUB.
  - Result is written back in place.
  - After digit DIGITS−1, go to DONE.
- DONE:
  - Hold for one cycle with done=1; busy=0.
  - diff is driven from the work register; negative and invalid are held.
  - Return to IDLE.
- Outputs:
  - diff, negative and invalid hold their values after DONE until the next accepted start.
  - All outputs are registered.
- Latency, counted from the clock edge that samples start to the edge that raises done:
  - DIGITS+1 when a ≥ b.
  - 2*DIGITS+1 when a < b.
  - 1 when invalid.
- busy is high in SUB and NEG only. start is ignored in SUB, NEG and DONE; there is no queueing.
- Wrap-around: none. The borrow out of the MSD determines sign only; the result is never larger than the largest DIGITS-digit BCD value.
- Equal operands: diff=0, negative=0, no NEG pass.

Test Plan:
- DIGITS=4: a=0x5000, b=0x1234, start pulse → done 5 edges later, diff=0x3766, negative=0, invalid=0, busy high for 4 cycles.
- a=0x1234, b=0x5000 → done 9 edges after start, diff=0x3766, negative=1.
- a=0x1000, b=0x0001 → diff=0x0999, negative=0 (full borrow chain); then a=0x0000, b=0x9999 → diff=0x9999, negative=1.
- a=0x0A00, b=0x0001 → done 1 edge after start, invalid=1, diff=0, negative=0; next valid start clears invalid.
- a=b=0x4321 → diff=0, negative=0, latency 5. A second start asserted while busy is ignored, and exactly one done pulse is produced.
- Assert rst_n=0 two cycles into a SUB pass → all outputs 0 immediately, no done pulse. A start after release runs normally.
